dechunker: RTL and testbench

- Reassembles a stream of M-bit words into L-bit blocks, MSB word first; inverse of the block-splitting stage.
- Sits downstream of word-serial links. It collects NR = L/M accepted words and emits one L-bit block with a one-cycle strobe.
- Output block is registered and held stable until the next completed block, so consumers may sample it lazily.

---
 rtl/chunk_pkg.sv | 15 +
 rtl/dechunker.sv | 79 +++++++
 tb/tb_dechunker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_pkg.sv
// Helpers shared by the block splitter and the dechunker: word-count
// derivation and the legality check for an (L, M) width pair.
package chunk_pkg;

    // Number of M-bit words that make up one L-bit block.
    function automatic int nr(input int l, input int m);
        return l / m;
    endfunction

    // An (L, M) pair is legal when the block is a whole number of words.
    function automatic bit params_ok(input int l, input int m);
        return (m > 0) && (m <= l) && ((l % m) == 0);
    endfunction

endpackage

// File: rtl/dechunker.sv
// Reassembles M-bit words into L-bit blocks, MSB word first. The completed
// block is registered in q and held until the next block completes. strobe
// pulses for one cycle whenever q is updated.
module dechunker
    import chunk_pkg::*;
#(
    parameter  int L  = 128,
    parameter  int M  = 32,
    localparam int NR = nr(L, M),
    localparam int CW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [M-1:0]  data_in,
    input  logic          valid_in,
    input  logic          align,
    output logic [L-1:0]  q,
    output logic          strobe,
    output logic          busy,
    output logic [CW-1:0] count
);

    // Refuse to elaborate a width pair that does not split into whole words.
    if (!params_ok(L, M)) begin : g_bad_params
        $error("dechunker: L (%0d) must be a non-zero multiple of M (%0d)", L, M);
    end

    localparam logic [CW-1:0] LAST_CNT = CW'(NR - 1);

    logic [L-1:0]  sr;
    logic [CW-1:0] cnt;
    logic [L-1:0]  sr_next;

    // Shifting by M and OR-ing in the new word keeps every sr bit in use and
    // degenerates cleanly to "sr_next = data_in" when a block is one word.
    assign sr_next = (sr << M) | L'(data_in);

    // Shift register, word counter, block register and strobe.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values; blocking would create ordering races.
        if (reset) begin
            sr     <= '0;
            cnt    <= '0;
            q      <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (valid_in) begin
                sr <= sr_next;
                if (align) begin
                    // The word arriving with align starts a fresh block; the
                    // partial block is dropped and no strobe is issued.
                    cnt <= (NR == 1) ? '0 : CW'(1);
                end else if (cnt == LAST_CNT) begin
                    q      <= sr_next;
                    strobe <= 1'b1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (align) begin
                cnt <= '0;
            end
        end
    end

    assign count = cnt;
    assign busy  = (cnt != '0);

    // Simulation sanity: a strobe always follows an accepted word, and the
    // counter never leaves its legal range.
    a_strobe_after_valid : assert property (
        @(posedge clk) disable iff (reset) strobe |-> $past(valid_in));

    a_cnt_in_range : assert property (
        @(posedge clk) disable iff (reset) cnt <= LAST_CNT);

endmodule

// File: tb/tb_dechunker.sv
// Self-checking bench for dechunker: a table of per-cycle vectors for the
// L=128/M=32 instance with a scoreboard of expected blocks, plus hand-written
// sequences for reset and the single-word (NR=1) instance.
module tb_dechunker;

    localparam int L  = 128;
    localparam int M  = 32;
    localparam int CW = $clog2(L / M + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [M-1:0]  data_in;
    logic          valid_in;
    logic          align;
    logic [L-1:0]  q;
    logic          strobe;
    logic          busy;
    logic [CW-1:0] count;

    logic [31:0]   data1;
    logic          valid1;
    logic          align1;
    logic [31:0]   q1;
    logic          strobe1;
    logic          busy1;
    logic [0:0]    count1;

    dechunker #(.L(L), .M(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .align    (align),
        .q        (q),
        .strobe   (strobe),
        .busy     (busy),
        .count    (count)
    );

    dechunker #(.L(32), .M(32)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data1),
        .valid_in (valid1),
        .align    (align1),
        .q        (q1),
        .strobe   (strobe1),
        .busy     (busy1),
        .count    (count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r;
        bit          v;
        bit          a;
        logic [31:0] d;
        int unsigned cnt;
        bit          stb;
        logic [127:0] qv;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] sb[$];
    logic [127:0] exp_q_hold;
    int           n_checks = 0;
    int           n_pass   = 0;

    localparam logic [127:0] Q1 = {32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    localparam logic [127:0] Q3A = {32'h1, 32'h2, 32'h3, 32'h4};
    localparam logic [127:0] Q3B = {32'h5, 32'h6, 32'h7, 32'h8};
    localparam logic [127:0] Q4 = {32'h33, 32'h44, 32'h55, 32'h66};
    localparam logic [127:0] QX = {32'hA, 32'hB, 32'hC, 32'hD};
    localparam logic [127:0] Q5 = {32'hE, 32'hF, 32'h10, 32'h11};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input bit r, input bit v, input bit a, input logic [31:0] d,
                                input int unsigned cnt, input bit stb, input logic [127:0] qv);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.d = d; t.cnt = cnt; t.stb = stb; t.qv = qv;
        vecs.push_back(t);
    endfunction

    // Drive one cycle of stimulus, then compare outputs #1 after the edge.
    task automatic apply(input vec_t t, input int idx);
        reset    = t.r;
        valid_in = t.v;
        align    = t.a;
        data_in  = t.d;
        if (t.stb) sb.push_back(t.qv);
        if (t.r) exp_q_hold = '0;
        @(posedge clk);
        #1;
        check($sformatf("v%0d strobe", idx), 128'(strobe), 128'(t.stb));
        if (strobe === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL v%0d unexpected strobe: got q=%0h with no block expected", idx, q);
            end else begin
                exp_q_hold = sb.pop_front();
            end
        end
        check($sformatf("v%0d q", idx), q, exp_q_hold);
        check($sformatf("v%0d count", idx), 128'(count), 128'(t.cnt));
        check($sformatf("v%0d busy", idx), 128'(busy), 128'(t.cnt != 0));
    endtask

    initial begin
        logic [31:0] w1[3];

        reset    = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        align    = 1'b0;
        data1    = '0;
        valid1   = 1'b0;
        align1   = 1'b0;
        exp_q_hold = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset q", q, '0);
        check("reset strobe", 128'(strobe), '0);
        check("reset busy", 128'(busy), '0);
        check("reset count", 128'(count), '0);
        check("reset q1", 128'(q1), '0);

        // Back-to-back block.
        add(0, 1, 0, 32'hA0000001, 1, 0, '0);
        add(0, 1, 0, 32'hB0000002, 2, 0, '0);
        add(0, 1, 0, 32'hC0000003, 3, 0, '0);
        add(0, 1, 0, 32'hD0000004, 0, 1, Q1);
        // Same words with three idle cycles between each.
        add(0, 1, 0, 32'hA0000001, 1, 0, '0);
        repeat (3) add(0, 0, 0, 32'hFFFFFFFF, 1, 0, '0);
        add(0, 1, 0, 32'hB0000002, 2, 0, '0);
        repeat (3) add(0, 0, 0, 32'hFFFFFFFF, 2, 0, '0);
        add(0, 1, 0, 32'hC0000003, 3, 0, '0);
        repeat (3) add(0, 0, 0, 32'hFFFFFFFF, 3, 0, '0);
        add(0, 1, 0, 32'hD0000004, 0, 1, Q1);
        // q must hold over a long idle stretch.
        repeat (20) add(0, 0, 0, 32'h12345678, 0, 0, '0);
        // Eight words streamed: strobes exactly four cycles apart.
        for (int i = 1; i <= 8; i++)
            add(0, 1, 0, 32'(i), (i % 4), (i % 4) == 0, (i == 4) ? Q3A : Q3B);
        // Align with a word mid-block restarts the block without a strobe.
        add(0, 1, 0, 32'h11, 1, 0, '0);
        add(0, 1, 0, 32'h22, 2, 0, '0);
        add(0, 1, 1, 32'h33, 1, 0, '0);
        add(0, 1, 0, 32'h44, 2, 0, '0);
        add(0, 1, 0, 32'h55, 3, 0, '0);
        add(0, 1, 0, 32'h66, 0, 1, Q4);
        // Align+word at count NR-1 gives no strobe; align alone clears count;
        // align at count 0 behaves like a plain accept.
        add(0, 1, 0, 32'h1, 1, 0, '0);
        add(0, 1, 0, 32'h2, 2, 0, '0);
        add(0, 1, 0, 32'h3, 3, 0, '0);
        add(0, 1, 1, 32'h9, 1, 0, '0);
        add(0, 0, 1, 32'h0, 0, 0, '0);
        add(0, 1, 1, 32'hA, 1, 0, '0);
        add(0, 1, 0, 32'hB, 2, 0, '0);
        add(0, 1, 0, 32'hC, 3, 0, '0);
        add(0, 1, 0, 32'hD, 0, 1, QX);
        // Reset mid-block drops the partial block and clears q.
        add(0, 1, 0, 32'h1, 1, 0, '0);
        add(0, 1, 0, 32'h2, 2, 0, '0);
        add(0, 1, 0, 32'h3, 3, 0, '0);
        add(1, 1, 0, 32'h4, 0, 0, '0);
        add(0, 1, 0, 32'hE, 1, 0, '0);
        add(0, 1, 0, 32'hF, 2, 0, '0);
        add(0, 1, 0, 32'h10, 3, 0, '0);
        add(0, 1, 0, 32'h11, 0, 1, Q5);
        add(0, 0, 0, 32'h0, 0, 0, '0);

        foreach (vecs[i]) apply(vecs[i], i);
        check("scoreboard drained", 128'(sb.size()), '0);

        // Single-word blocks: every accepted word strobes, q follows a cycle later.
        reset    = 1'b0;
        valid_in = 1'b0;
        align    = 1'b0;
        w1[0] = 32'h5; w1[1] = 32'h6; w1[2] = 32'h7;
        for (int i = 0; i < 3; i++) begin
            valid1 = 1'b1;
            data1  = w1[i];
            @(posedge clk);
            #1;
            check($sformatf("nr1 strobe %0d", i), 128'(strobe1), 128'(1));
            check($sformatf("nr1 q %0d", i), 128'(q1), 128'(w1[i]));
            check($sformatf("nr1 busy %0d", i), 128'(busy1), '0);
            check($sformatf("nr1 count %0d", i), 128'(count1), '0);
        end
        valid1 = 1'b0;
        data1  = 32'hDEAD;
        @(posedge clk);
        #1;
        check("nr1 idle strobe", 128'(strobe1), '0);
        check("nr1 idle q", 128'(q1), 128'(32'h7));
        valid1 = 1'b1;
        align1 = 1'b1;
        data1  = 32'h8;
        @(posedge clk);
        #1;
        check("nr1 align strobe", 128'(strobe1), '0);
        check("nr1 align q", 128'(q1), 128'(32'h7));
        align1 = 1'b0;
        data1  = 32'h9;
        @(posedge clk);
        #1;
        check("nr1 post-align strobe", 128'(strobe1), 128'(1));
        check("nr1 post-align q", 128'(q1), 128'(32'h9));
        valid1 = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
